// File: rtl/vdp_cpu_port_if.sv
// VRAM access channel between the CPU port decoder and the VRAM arbiter.
// It uses a single-outstanding req/ack handshake.
interface vdp_cpu_port_if #(
    parameter int ADDR_W = 14
);
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_ack;
    logic [7:0]        vram_rdata;

    modport master (
        output vram_req, vram_we, vram_addr, vram_wdata,
        input  vram_ack, vram_rdata
    );

    modport slave (
        input  vram_req, vram_we, vram_addr, vram_wdata,
        output vram_ack, vram_rdata
    );
endinterface

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port decoder: control-port register/address writes,
// data-port VRAM access with auto-increment, and a VRAM read-ahead buffer.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | no VRAM access outstanding; strobes are accepted
//   WREQ  | VRAM write requested, waiting for vram_ack
//   RREQ  | VRAM read (prefetch) requested, waiting for vram_ack
module vdp_cpu_port #(
    parameter int ADDR_W = 14
) (
    input  logic       phi,
    input  logic       reset,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic       mode,
    input  logic [7:0] din,
    output logic       reg_we,
    output logic [2:0] reg_num,
    output logic [7:0] reg_data,
    output logic       status_rd,
    output logic [7:0] rd_buf,
    output logic       overrun,
    vdp_cpu_port_if.master vram
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WREQ = 2'd1,
        RREQ = 2'd2
    } state_t;

    state_t            state;
    logic              second;
    logic [7:0]        tmp;
    logic [ADDR_W-1:0] addr;
    logic              req_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic              busy;

    // busy is taken from the pre-edge state, so a strobe that coincides
    // with the completing ack is still treated as a collision and dropped.
    assign busy = (state != IDLE);

    assign vram.vram_req   = req_q;
    assign vram.vram_we    = we_q;
    assign vram.vram_addr  = addr;
    assign vram.vram_wdata = wdata_q;

    always_ff @(negedge phi) begin
        if (reset) begin
            state     <= IDLE;
            second    <= 1'b0;
            tmp       <= 8'h00;
            addr      <= '0;
            rd_buf    <= 8'h00;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
            reg_we    <= 1'b0;
            reg_num   <= 3'd0;
            reg_data  <= 8'h00;
            status_rd <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            status_rd <= 1'b0;

            if (busy && vram.vram_ack) begin
                if (state == RREQ) begin
                    rd_buf <= vram.vram_rdata;
                end
                addr  <= addr + ADDR_W'(1);
                state <= IDLE;
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end

            if (wr_tick) begin
                if (mode) begin
                    if (!second) begin
                        tmp    <= din;
                        second <= 1'b1;
                    end else begin
                        second <= 1'b0;
                        if (din[7]) begin
                            reg_we   <= 1'b1;
                            reg_num  <= din[2:0];
                            reg_data <= tmp;
                        end else if (!busy) begin
                            addr <= ADDR_W'({din[5:0], tmp});
                            if (!din[6]) begin
                                state <= RREQ;
                                req_q <= 1'b1;
                                we_q  <= 1'b0;
                            end
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end else begin
                    second <= 1'b0;
                    if (!busy) begin
                        wdata_q <= din;
                        rd_buf  <= din;
                        state   <= WREQ;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end else if (rd_tick) begin
                second <= 1'b0;
                if (mode) begin
                    status_rd <= 1'b1;
                end else if (!busy) begin
                    state <= RREQ;
                    req_q <= 1'b1;
                    we_q  <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
